// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported RAM between an instruction-fetch port and a
//   data port, and diverts data accesses at or above UART_BASE to a byte
//   UART. Data has priority over fetch, but fetch can be denied for no more
//   than STARVE_LIMIT consecutive cycles while it keeps requesting.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | arbitrate fetch vs. data each cycle; UART loads answered
//   UART_WAIT | UART byte offered and held; data port stalled, fetch free
//
// Ports
//   clk, reset          clock, synchronous active-low reset
//   if_*                fetch port: req/addr(word) in, gnt/rvalid/rdata out
//   d_*                 data port: req/we/addr(byte)/wdata/be in,
//                       gnt/rvalid/rdata out
//   mem_*               RAM port: en/we/addr(word)/wdata/be out, rdata in
//                       (rdata valid one cycle after a read strobe)
//   uart_valid/wdata    byte offer to the UART, uart_ready accepts it
module mem_port_arbiter #(
  parameter logic [31:0] UART_BASE    = 32'h10000004,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  output logic        uart_valid,
  output logic [7:0]  uart_wdata,
  input  logic        uart_ready
);

  // Wide enough to hold STARVE_LIMIT (at least one bit even for a limit of 0).
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 2);

  typedef enum logic {IDLE, UART_WAIT} state_t;

  state_t        state, state_next;
  logic [SW-1:0] starve_cnt;
  logic          if_pend, d_pend, d_pend_uart;
  logic          d_uart, d_ram_req, starve_max, d_ram_gnt;

  assign d_uart     = (d_addr >= UART_BASE);
  assign d_ram_req  = d_req && !d_uart;
  assign starve_max = (starve_cnt == SW'(STARVE_LIMIT));

  always_comb begin
    state_next = state;
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    d_ram_gnt  = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;
    mem_be     = 4'h0;
    if (reset) begin
      case (state)
        IDLE: begin
          // UART accesses never touch the RAM, so fetch may run alongside them.
          if (d_req && d_uart) begin
            if (d_we) state_next = UART_WAIT;
            else      d_gnt      = 1'b1;
          end
          if (if_req && (!d_ram_req || starve_max)) begin
            if_gnt = 1'b1;
          end else if (d_ram_req) begin
            d_gnt     = 1'b1;
            d_ram_gnt = 1'b1;
          end
        end
        UART_WAIT: begin
          if_gnt = if_req;
          if (uart_ready) begin
            d_gnt      = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
      if (if_gnt) begin
        mem_en   = 1'b1;
        mem_addr = if_addr;
        mem_be   = 4'hF;
      end else if (d_ram_gnt) begin
        mem_en    = 1'b1;
        mem_we    = d_we;
        mem_addr  = {2'b00, d_addr[31:2]};
        mem_wdata = d_wdata;
        mem_be    = d_be;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      if_pend     <= 1'b0;
      d_pend      <= 1'b0;
      d_pend_uart <= 1'b0;
      uart_wdata  <= 8'h0;
    end else begin
      state       <= state_next;
      if_pend     <= if_gnt;
      d_pend      <= d_gnt && !d_we;
      d_pend_uart <= d_uart;
      if (state == IDLE && state_next == UART_WAIT) uart_wdata <= d_wdata[7:0];
      if (!if_req || if_gnt || state == UART_WAIT) starve_cnt <= '0;
      else if (!starve_max)                        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign uart_valid = (state == UART_WAIT);
  assign if_rvalid  = if_pend;
  assign d_rvalid   = d_pend;
  assign if_rdata   = if_pend ? mem_rdata : 32'h0;
  // UART loads return zero even though the RAM read bus may carry a fetch.
  assign d_rdata    = (d_pend && !d_pend_uart) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam logic [31:0] BASE  = 32'h10000004;
  localparam int          LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        uart_valid;
  logic [7:0]  uart_wdata;
  logic        uart_ready;

  mem_port_arbiter #(.UART_BASE(BASE), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .uart_valid(uart_valid), .uart_wdata(uart_wdata), .uart_ready(uart_ready)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: transaction-level view of the arbiter.
  bit       m_uart_busy;       // a UART byte is being offered
  bit [7:0] m_uart_byte;
  int       m_denied;          // consecutive cycles fetch asked and lost
  bit       m_if_resp, m_d_resp, m_d_resp_zero;

  bit        e_if_gnt, e_d_gnt, e_mem_en, e_mem_we;
  bit [31:0] e_mem_addr, e_mem_wdata;
  bit [3:0]  e_mem_be;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic bit is_uart(input logic [31:0] a);
    return a >= BASE;
  endfunction

  // Decide what the current cycle's grants and RAM strobe should be.
  task automatic model_eval();
    bit ram_data, fetch_wins;
    e_if_gnt = 0; e_d_gnt = 0; e_mem_en = 0; e_mem_we = 0;
    e_mem_addr = 0; e_mem_wdata = 0; e_mem_be = 0;
    fetch_wins = 0;
    if (reset) begin
      if (m_uart_busy) begin
        fetch_wins = if_req;
        e_d_gnt    = uart_ready;
      end else begin
        ram_data = d_req && !is_uart(d_addr);
        if (d_req && is_uart(d_addr) && !d_we) e_d_gnt = 1;
        fetch_wins = if_req && (!ram_data || m_denied >= LIMIT);
        if (ram_data && !fetch_wins) begin
          e_d_gnt = 1; e_mem_en = 1; e_mem_we = d_we;
          e_mem_addr = d_addr / 4; e_mem_wdata = d_wdata; e_mem_be = d_be;
        end
      end
      if (fetch_wins) begin
        e_if_gnt = 1; e_mem_en = 1; e_mem_addr = if_addr; e_mem_be = 4'hF;
      end
    end
  endtask

  task automatic model_advance();
    if (!reset) begin
      m_uart_busy = 0; m_uart_byte = 0; m_denied = 0;
      m_if_resp = 0; m_d_resp = 0; m_d_resp_zero = 0;
    end else begin
      m_if_resp     = e_if_gnt;
      m_d_resp      = e_d_gnt && !d_we;
      m_d_resp_zero = is_uart(d_addr);
      if (!if_req || e_if_gnt || m_uart_busy) m_denied = 0;
      else if (m_denied < LIMIT)              m_denied++;
      if (m_uart_busy) begin
        if (uart_ready) m_uart_busy = 0;
      end else if (d_req && d_we && is_uart(d_addr)) begin
        m_uart_busy = 1;
        m_uart_byte = d_wdata[7:0];
      end
    end
  endtask

  // Apply read data, wait to mid-cycle and compare everything with the model.
  task automatic sample(input logic [31:0] rd);
    mem_rdata = rd;
    @(negedge clk);
    model_eval();
    chk("grants", {if_gnt, d_gnt}, {e_if_gnt, e_d_gnt});
    chk("mem_ctl", {mem_en, mem_we, mem_be, mem_addr}, {e_mem_en, e_mem_we, e_mem_be, e_mem_addr});
    chk("mem_wdata", mem_wdata, e_mem_wdata);
    chk("if_resp", {if_rvalid, if_rdata}, {m_if_resp, (m_if_resp ? rd : 32'h0)});
    chk("d_resp", {d_rvalid, d_rdata}, {m_d_resp, ((m_d_resp && !m_d_resp_zero) ? rd : 32'h0)});
    chk("uart", {uart_valid, uart_wdata}, {m_uart_busy, m_uart_byte});
  endtask

  task automatic advance();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
    d_wdata = 0; d_be = 0; uart_ready = 0;
  endtask

  initial begin
    int vcnt, gcnt, men;
    bit        r_active;
    bit [31:0] r_addr;
    reset = 0; mem_rdata = 0;
    idle_inputs();
    @(posedge clk); #1;

    // Reset: everything quiet even with requests present.
    if_req = 1; d_req = 1; d_addr = 32'h40;
    sample(32'h12345678);
    chk("rst_grants", {if_gnt, d_gnt, mem_en}, 3'b000);
    advance();
    sample(32'h12345678);
    chk("rst_regs", {if_rvalid, d_rvalid, uart_valid, uart_wdata}, 11'h0);
    advance();
    idle_inputs();
    reset = 1;

    // Fetch-only read.
    if_req = 1; if_addr = 32'h10;
    sample($urandom);
    chk("f_gnt", {if_gnt, mem_en, mem_we, mem_addr, mem_be}, {3'b110, 32'h10, 4'hF});
    advance();
    if_req = 0;
    sample(32'hDEADBEEF);
    chk("f_resp", {if_rvalid, if_rdata}, {1'b1, 32'hDEADBEEF});
    advance();
    sample($urandom);
    chk("f_resp_gone", {if_rvalid, if_rdata}, 33'h0);
    advance();

    // UART store with three stalled cycles.
    d_req = 1; d_we = 1; d_addr = 32'h10000004; d_wdata = 32'h41; d_be = 4'hF;
    vcnt = 0; gcnt = 0; men = 0;
    for (int i = 0; i < 6; i++) begin
      uart_ready = (i >= 4);
      sample($urandom);
      vcnt += int'(uart_valid);
      gcnt += int'(d_gnt);
      men  += int'(mem_en);
      if (i == 4) chk("u_hs", {d_gnt, uart_valid, uart_wdata}, {2'b11, 8'h41});
      advance();
      if (i == 4) d_req = 0;
    end
    chk("u_valid_cycles", vcnt, 4);
    chk("u_gnt_count", gcnt, 1);
    chk("u_no_ram", men, 0);
    idle_inputs();

    // UART load returns zero next cycle.
    d_req = 1; d_addr = 32'h10000008;
    sample($urandom);
    chk("ul_gnt", {d_gnt, mem_en}, 2'b10);
    advance();
    d_req = 0;
    sample(32'hCAFEF00D);
    chk("ul_resp", {d_rvalid, d_rdata}, {1'b1, 32'h0});
    advance();

    // RAM store with partial byte enables.
    d_req = 1; d_we = 1; d_addr = 32'h8; d_be = 4'b0011; d_wdata = 32'hA5A5_1234;
    sample($urandom);
    chk("rs_mem", {d_gnt, mem_en, mem_we, mem_addr, mem_be}, {3'b111, 32'h2, 4'b0011});
    advance();
    idle_inputs();
    sample($urandom);
    chk("rs_no_rvalid", d_rvalid, 1'b0);
    advance();

    // Reset during UART_WAIT aborts the store.
    if_req = 1; if_addr = 32'h20;
    d_req = 1; d_we = 1; d_addr = 32'h10000010; d_wdata = 32'h5A;
    sample($urandom); advance();
    sample($urandom); advance();
    uart_ready = 1; reset = 0;
    sample($urandom);
    chk("ra_no_gnt", {d_gnt, if_gnt}, 2'b00);
    advance();
    reset = 1; d_req = 0; uart_ready = 0; if_req = 0;
    sample($urandom);
    chk("ra_uart_off", uart_valid, 1'b0);
    advance();

    // Fetch vs. RAM load contention from a cleared starve count.
    if_req = 1; if_addr = 32'h80; d_req = 1; d_we = 0; d_addr = 32'h40;
    for (int i = 0; i < 7; i++) begin
      sample($urandom);
      chk("starve_gnt", {if_gnt, d_gnt}, (i == 4) ? 2'b10 : 2'b01);
      if (i != 4) chk("starve_addr", mem_addr, 32'h10);
      advance();
    end
    idle_inputs();

    // Random traffic; data requests held stable until granted.
    r_active = 0;
    for (int c = 0; c < 400; c++) begin
      reset  = ($urandom_range(0, 99) >= 3);
      if_req = ($urandom_range(0, 9) < 7);
      if_addr = $urandom;
      uart_ready = ($urandom_range(0, 9) < 4);
      if (!r_active && $urandom_range(0, 1) == 1) begin
        r_active = 1;
        case ($urandom_range(0, 4))
          0: r_addr = BASE + $urandom_range(0, 15);
          1: r_addr = BASE - 1;
          2: r_addr = BASE;
          default: r_addr = $urandom & 32'h0FFF_FFFF;
        endcase
        d_addr  = r_addr;
        d_we    = $urandom_range(0, 1) == 1;
        d_wdata = $urandom;
        d_be    = 4'($urandom);
      end
      d_req = r_active;
      sample($urandom);
      if (e_d_gnt || !reset) r_active = 0;
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter UART_BASE, default 32'h10000004: byte addresses >= UART_BASE decode to the UART; lower addresses decode to RAM.
REQ-002 Parameter STARVE_LIMIT, default 4: maximum number of consecutive cycles fetch may be denied while requesting.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 if_req  input  1  instruction fetch request.
REQ-006 if_addr  input  32  fetch word address.
REQ-007 if_gnt  output  1  fetch accepted this cycle.
REQ-008 if_rvalid  output  1  fetch data valid.
REQ-009 if_rdata  output  32  fetch data.
REQ-010 d_req  input  1  data request; held with stable fields until d_gnt.
REQ-011 d_we  input  1  1 = store, 0 = load.
REQ-012 d_addr  input  32  data byte address.
REQ-013 d_wdata  input  32  store data.
REQ-014 d_be  input  4  store byte enables.
REQ-015 d_gnt  output  1  data access accepted this cycle.
REQ-016 d_rvalid  output  1  load data valid.
REQ-017 d_rdata  output  32  load data.
REQ-018 mem_en  output  1  RAM access strobe.
REQ-019 mem_we  output  1  RAM write.
REQ-020 mem_addr  output  32  RAM word address.
REQ-021 mem_wdata  output  32  RAM write data.
REQ-022 mem_be  output  4  RAM byte enables.
REQ-023 mem_rdata  input  32  RAM read data, valid exactly 1 cycle after mem_en with mem_we=0.
REQ-024 uart_valid  output  1  UART byte offer.
REQ-025 uart_wdata  output  8  UART byte.
REQ-026 uart_ready  input  1  UART accepts the byte when asserted together with uart_valid.

Function
REQ-027 FSM states: IDLE and UART_WAIT; one RAM access per cycle.
REQ-028 RAM-region data requests: mem_addr = d_addr >> 2; mem_en, mem_we, mem_wdata, mem_be and d_gnt are combinational in the same cycle.
REQ-029 Fetch requests: mem_addr = if_addr; mem_we = 0; mem_be = 4'hF; if_gnt is combinational in the same cycle.
REQ-030 Arbitration when both if_req and RAM-region d_req are asserted: data wins while starve_cnt < STARVE_LIMIT; fetch wins when starve_cnt == STARVE_LIMIT.
REQ-031 starve_cnt is a saturating counter: +1 each cycle if_req is high and if_gnt is low; cleared when if_gnt is asserted or if_req is low.
REQ-032 Read response: if_rvalid or d_rvalid is registered, asserted exactly 1 cycle after the grant, with rdata = mem_rdata.
REQ-033 Back-to-back grants are legal; the response of cycle N and a grant in cycle N+1 coexist.
REQ-034 Stores produce no rvalid.
REQ-035 UART store (d_we=1, d_addr >= UART_BASE), from IDLE: enter UART_WAIT; uart_valid=1, uart_wdata=d_wdata[7:0]; no RAM access.
REQ-036 UART_WAIT: uart_valid and uart_wdata are held stable until uart_ready; in the handshake cycle d_gnt=1 and the FSM returns to IDLE next cycle.
REQ-037 During UART_WAIT, fetch is granted RAM access unconditionally and starve_cnt is cleared.
REQ-038 UART-region load: d_gnt the same cycle, no RAM access; d_rvalid=1 with d_rdata=0 one cycle later.
REQ-039 When no grant occurs, mem_en=0 and all RAM outputs are 0.
REQ-040 if_rdata and d_rdata are 0 whenever the corresponding rvalid is 0.

Reset
REQ-041 While reset=0 at a clock edge: FSM=IDLE, starve_cnt=0, if_rvalid=0, d_rvalid=0, uart_valid=0, uart_wdata=0.
REQ-042 Combinational grants and mem_en are 0 while reset=0.
REQ-043 Reset asserted in UART_WAIT: uart_valid drops the following cycle; no d_gnt is issued for the aborted store.
REQ-044 A read response pending at reset is discarded: no rvalid after reset.

Verification
REQ-045 Fetch-only, if_addr=0x10, mem_rdata=0xDEADBEEF next cycle -> if_gnt in cycle 0; if_rvalid=1, if_rdata=0xDEADBEEF in cycle 1.
REQ-046 if_req and d_req (load, d_addr=0x40) held continuously, STARVE_LIMIT=4 -> d_gnt cycles 0-3, if_gnt cycle 4, then d_gnt resumes; mem_addr=0x10 on data cycles.
REQ-047 Store d_addr=0x10000004, d_wdata=0x41, uart_ready low for 3 cycles then high -> uart_valid=1 for 4 cycles, uart_wdata=0x41, single d_gnt in cycle 4, mem_en never set for data.
REQ-048 Load d_addr=0x10000008 -> d_gnt cycle 0; d_rvalid=1, d_rdata=0 cycle 1; mem_en=0.
REQ-049 Reset pulled low during UART_WAIT -> uart_valid=0 next cycle, FSM IDLE, no d_gnt, starve_cnt=0.
REQ-050 Store to RAM d_addr=0x8, d_be=4'b0011 -> mem_en=1, mem_we=1, mem_addr=0x2, mem_be=4'b0011 same cycle; no d_rvalid.
